// File: rtl/npu_conv_pkg.sv
// Shared definitions for the convolution window engine: FSM encoding,
// kernel size limits and the default image geometry.
package npu_conv_pkg;

  localparam int MAX_KERNEL_SIZE   = 5;
  localparam int MAX_KERNEL_TAPS   = 25;
  localparam int DEFAULT_IMG_WIDTH = 28;
  localparam int DEFAULT_ACC_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_OUT
  } conv_state_t;

  function automatic logic kernel_size_legal(input logic [2:0] k);
    return (k != 3'd0) && (k <= 3'(MAX_KERNEL_SIZE));
  endfunction

endpackage

// File: rtl/conv_window_engine_if.sv
// Result stream between the window engine and the next NPU stage:
// one signed accumulated result per output pixel over valid/ready.
interface conv_window_engine_if
  import npu_conv_pkg::*;
#(
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
);

  logic [ACC_WIDTH-1:0] result;
  logic                 result_valid;
  logic                 result_ready;

  modport master (output result, output result_valid, input result_ready);
  modport slave  (input result, input result_valid, output result_ready);

endinterface

// File: rtl/kernel_reg_file.sv
// Kernel weight storage: 25 weights, gated write port, combinational read by
// tap index (out-of-range indices read as zero).
module kernel_reg_file
  import npu_conv_pkg::*;
#(
  parameter int WEIGHT_WIDTH = 8,
  parameter int ADDR_WIDTH   = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [WEIGHT_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]   rd_idx,
  output logic [WEIGHT_WIDTH-1:0] rd_data
);

  logic [WEIGHT_WIDTH-1:0] regs [MAX_KERNEL_TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_KERNEL_TAPS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (int'(wr_addr) < MAX_KERNEL_TAPS)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (int'(rd_idx) < MAX_KERNEL_TAPS) ? regs[rd_idx] : '0;

endmodule

// File: rtl/conv_window_engine.sv
// Valid-mode KxK convolution sweep over a square BRAM image, one result per
// window in row-major order. Define CONV_RELU_EN to clamp negative results to 0.
module conv_window_engine
  import npu_conv_pkg::*;
#(
  parameter int KERNEL_REG_ADDR_WIDTH = 5,
  parameter int BRAM_ADDR_WIDTH       = 10,
  parameter int WEIGHT_WIDTH          = 8,
  parameter int PIXEL_WIDTH           = 8,
  parameter int IMG_WIDTH             = DEFAULT_IMG_WIDTH,
  parameter int ACC_WIDTH             = DEFAULT_ACC_WIDTH
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_kernal_wr_en,
  input  logic [KERNEL_REG_ADDR_WIDTH-1:0] i_kernal_reg_addr,
  input  logic [WEIGHT_WIDTH-1:0]          i_kernal_data,
  input  logic                             i_start,
  input  logic [2:0]                       i_kernal_size,
  input  logic [BRAM_ADDR_WIDTH-1:0]       i_img_base_addr,
  output logic [BRAM_ADDR_WIDTH-1:0]       o_bram_address,
  input  logic [PIXEL_WIDTH-1:0]           i_bram_data,
  conv_window_engine_if.master             res,
  output logic                             o_busy,
  output logic                             o_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int PW = WEIGHT_WIDTH + PIXEL_WIDTH + 1;

  conv_state_t state, state_next;

  logic [2:0]                       k_q;
  logic [BRAM_ADDR_WIDTH-1:0]       base_q;
  logic [CW-1:0]                    row, col;
  logic [2:0]                       kx, ky;
  logic [KERNEL_REG_ADDR_WIDTH-1:0] tap, acc_tap;
  logic signed [ACC_WIDTH-1:0]      acc;
  logic                             done_q;

  logic                             start_legal;
  logic [KERNEL_REG_ADDR_WIDTH-1:0] taps_m1;
  logic [CW-1:0]                    pos_last;
  logic                             kx_last, row_last, col_last, last_tap;
  logic [WEIGHT_WIDTH-1:0]          weight;
  logic signed [PW-1:0]             w_ext, p_ext, prod;
  logic signed [ACC_WIDTH-1:0]      prod_ext;

  kernel_reg_file #(
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .ADDR_WIDTH  (KERNEL_REG_ADDR_WIDTH)
  ) u_kernel_reg_file (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .wr_en  (i_kernal_wr_en && (state == ST_IDLE)),
    .wr_addr(i_kernal_reg_addr),
    .wr_data(i_kernal_data),
    .rd_idx (acc_tap),
    .rd_data(weight)
  );

  assign start_legal = kernel_size_legal(i_kernal_size);
  assign taps_m1     = KERNEL_REG_ADDR_WIDTH'(k_q) * KERNEL_REG_ADDR_WIDTH'(k_q)
                       - KERNEL_REG_ADDR_WIDTH'(1);
  assign last_tap    = (tap == taps_m1);
  assign kx_last     = (kx == k_q - 3'd1);
  assign pos_last    = CW'(IMG_WIDTH) - CW'(k_q);
  assign row_last    = (row == pos_last);
  assign col_last    = (col == pos_last);

  assign o_bram_address = base_q
                        + (BRAM_ADDR_WIDTH'(row) + BRAM_ADDR_WIDTH'(ky)) * BRAM_ADDR_WIDTH'(IMG_WIDTH)
                        + BRAM_ADDR_WIDTH'(col) + BRAM_ADDR_WIDTH'(kx);

  // Data on i_bram_data belongs to the tap addressed one cycle earlier, whose
  // index is held in acc_tap so the weight read lines up with the pixel.
  assign w_ext    = {{(PW-WEIGHT_WIDTH){weight[WEIGHT_WIDTH-1]}}, weight};
  assign p_ext    = {{(PW-PIXEL_WIDTH){1'b0}}, i_bram_data};
  assign prod     = w_ext * p_ext;
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (i_start && start_legal) state_next = ST_FETCH;
      ST_FETCH: if (last_tap) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_OUT;
      ST_OUT: begin
        if (res.result_ready) begin
          state_next = (row_last && col_last) ? ST_IDLE : ST_FETCH;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      k_q     <= '0;
      base_q  <= '0;
      row     <= '0;
      col     <= '0;
      kx      <= '0;
      ky      <= '0;
      tap     <= '0;
      acc_tap <= '0;
      acc     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            if (start_legal) begin
              k_q    <= i_kernal_size;
              base_q <= i_img_base_addr;
              row    <= '0;
              col    <= '0;
              kx     <= '0;
              ky     <= '0;
              tap    <= '0;
              acc    <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (tap != '0) acc <= acc + prod_ext;
          acc_tap <= tap;
          if (!last_tap) begin
            tap <= tap + KERNEL_REG_ADDR_WIDTH'(1);
            if (kx_last) begin
              kx <= '0;
              ky <= ky + 3'd1;
            end else begin
              kx <= kx + 3'd1;
            end
          end
        end
        ST_DRAIN: acc <= acc + prod_ext;
        ST_OUT: begin
          // Counters stay frozen under backpressure; the transfer edge moves
          // straight on to the next window's tap 0.
          if (res.result_ready) begin
            if (row_last && col_last) begin
              done_q <= 1'b1;
            end else if (col_last) begin
              col <= '0;
              row <= row + CW'(1);
            end else begin
              col <= col + CW'(1);
            end
            tap <= '0;
            kx  <= '0;
            ky  <= '0;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign res.result_valid = (state == ST_OUT);
  assign o_busy           = (state != ST_IDLE);
  assign o_done           = done_q;

`ifdef CONV_RELU_EN
  assign res.result = acc[ACC_WIDTH-1] ? '0 : acc;
`else
  assign res.result = acc;
`endif

endmodule

// File: tb/tb_conv_window_engine.sv
// Scoreboard bench for conv_window_engine: a BRAM model feeds the DUT, expected
// window sums are queued at sweep start and popped on each result transfer.
module tb_conv_window_engine;

  localparam int IMG = 28;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        kernal_wr_en;
  logic [4:0]  kernal_reg_addr;
  logic [7:0]  kernal_data;
  logic        start;
  logic [2:0]  kernal_size;
  logic [9:0]  img_base_addr;
  logic [9:0]  bram_address;
  logic [7:0]  bram_data;
  logic        busy;
  logic        done;

  conv_window_engine_if #(.ACC_WIDTH(24)) res_if ();

  conv_window_engine #(
    .KERNEL_REG_ADDR_WIDTH(5),
    .BRAM_ADDR_WIDTH      (10),
    .WEIGHT_WIDTH         (8),
    .PIXEL_WIDTH          (8),
    .IMG_WIDTH            (IMG),
    .ACC_WIDTH            (24)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_kernal_wr_en   (kernal_wr_en),
    .i_kernal_reg_addr(kernal_reg_addr),
    .i_kernal_data    (kernal_data),
    .i_start          (start),
    .i_kernal_size    (kernal_size),
    .i_img_base_addr  (img_base_addr),
    .o_bram_address   (bram_address),
    .i_bram_data      (bram_data),
    .res              (res_if),
    .o_busy           (busy),
    .o_done           (done)
  );

  always #5 clk = ~clk;

  logic [7:0]        mem [1024];
  logic signed [7:0] w_model [32];
  logic [23:0]       exp_q [$];

  int checks       = 0;
  int failures     = 0;
  int result_count = 0;
  int done_count   = 0;
  int exp_total    = 0;
  int rdy_mode     = 0;

  always @(posedge clk) bram_data <= mem[bram_address];

  // Ready policy: 0 = always high, 1 = random, otherwise held low.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       res_if.result_ready = 1'b1;
      1:       res_if.result_ready = 1'($urandom_range(0, 1));
      default: res_if.result_ready = 1'b0;
    endcase
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [23:0] e;
    if (res_if.result_valid && res_if.result_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_result", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_output("result", {8'd0, res_if.result}, {8'd0, e});
      end
      result_count++;
    end
    if (done) begin
      done_count++;
      check_output("done_while_busy", {31'd0, busy}, 32'd0);
    end
  end

  function automatic logic [23:0] window_model(input int k, input int base, input int r, input int c);
    int          sum;
    logic [31:0] s;
    logic [23:0] v;
    sum = 0;
    for (int ky = 0; ky < k; ky++) begin
      for (int kx = 0; kx < k; kx++) begin
        sum += int'(w_model[ky*k + kx]) * int'(mem[(base + (r + ky) * IMG + c + kx) % 1024]);
      end
    end
    s = sum;
    v = s[23:0];
`ifdef CONV_RELU_EN
    if (sum < 0) v = '0;
`endif
    return v;
  endfunction

  task automatic write_weight(input int idx, input int val, input bit accept);
    kernal_wr_en    = 1'b1;
    kernal_reg_addr = 5'(idx);
    kernal_data     = 8'(val);
    @(posedge clk); #1;
    kernal_wr_en = 1'b0;
    if (accept) w_model[idx] = 8'(val);
  endtask

  task automatic apply_stimulus(input int k, input int base);
    int n;
    result_count = 0;
    exp_total    = 0;
    if (k >= 1 && k <= 5) begin
      n = IMG - k + 1;
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < n; c++) begin
          exp_q.push_back(window_model(k, base, r, c));
        end
      end
      exp_total = n * n;
    end
    start         = 1'b1;
    kernal_size   = 3'(k);
    img_base_addr = 10'(base);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0;
    bit seen;
    d0   = done_count;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_count != d0) begin
        seen = 1'b1;
        break;
      end
    end
    check_output({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_output({tag, "_done_pulses"}, done_count - d0, 32'd1);
    check_output({tag, "_result_count"}, result_count, exp_total);
    check_output({tag, "_queue_left"}, exp_q.size(), 32'd0);
    check_output({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check_output({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    exp_q.delete();
  endtask

  initial begin : main
    logic [9:0]  held_addr;
    logic [23:0] held_exp;
    bit          got_v;
    int          d0;

    rst_n           = 1'b0;
    kernal_wr_en    = 1'b0;
    kernal_reg_addr = '0;
    kernal_data     = '0;
    start           = 1'b0;
    kernal_size     = '0;
    img_base_addr   = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    for (int i = 0; i < 32; i++) w_model[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_addr", {22'd0, bram_address}, 32'd0);
    check_output("reset_result", {8'd0, res_if.result}, 32'd0);
    check_output("reset_valid", {31'd0, res_if.result_valid}, 32'd0);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] K=3 all-ones kernel over ramp image");
    for (int i = 0; i < 25; i++) write_weight(i, 1, 1'b1);
    write_weight(25, 8'h55, 1'b1);
    rdy_mode = 0;
    apply_stimulus(3, 0);
    check_output("tap0_addr", {22'd0, bram_address}, 32'd0);
    check_output("busy_after_start", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check_output("tap1_addr", {22'd0, bram_address}, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check_output("valid_before_e10", {31'd0, res_if.result_valid}, 32'd0);
    @(posedge clk); #1;
    check_output("valid_at_e10", {31'd0, res_if.result_valid}, 32'd1);
    check_output("first_result_261", {8'd0, res_if.result}, 32'd261);
    wait_done(676 * 11 + 50, "k3_ramp");

    $display("[TB] K=3 with backpressure on the first result");
    rdy_mode = 2;
    @(posedge clk); #1;
    apply_stimulus(3, 0);
    got_v = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (res_if.result_valid) begin
        got_v = 1'b1;
        break;
      end
    end
    check_output("hold_valid_seen", {31'd0, got_v}, 32'd1);
    held_addr = bram_address;
    held_exp  = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("hold_valid", {31'd0, res_if.result_valid}, 32'd1);
      check_output("hold_result", {8'd0, res_if.result}, {8'd0, held_exp});
      check_output("hold_addr", {22'd0, bram_address}, {22'd0, held_addr});
    end
    rdy_mode = 0;
    @(posedge clk); #2;
    check_output("addr_before_transfer", {22'd0, bram_address}, {22'd0, held_addr});
    @(posedge clk); #1;
    check_output("next_window_tap0_addr", {22'd0, bram_address}, 32'd1);
    wait_done(676 * 11 + 100, "k3_hold");

    $display("[TB] K=3 single negative tap over flat image");
    for (int i = 0; i < 1024; i++) mem[i] = 8'd200;
    for (int i = 0; i < 25; i++) write_weight(i, (i == 4) ? 8'hFF : 0, 1'b1);
    apply_stimulus(3, 0);
    got_v = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (res_if.result_valid) begin
        got_v = 1'b1;
        break;
      end
    end
    check_output("neg_valid_seen", {31'd0, got_v}, 32'd1);
`ifdef CONV_RELU_EN
    check_output("neg_result", {8'd0, res_if.result}, 32'd0);
`else
    check_output("neg_result", {8'd0, res_if.result}, 32'h00FF_FF38);
`endif
    wait_done(676 * 11 + 50, "k3_neg");

    $display("[TB] K=1 weight 2 over random image, write while busy");
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
    write_weight(0, 2, 1'b1);
    apply_stimulus(1, 500);
    write_weight(0, 5, 1'b0);
    wait_done(784 * 3 + 50, "k1");

    $display("[TB] K=5 sweep with wrapped addressing");
    apply_stimulus(5, 300);
    wait_done(576 * 27 + 50, "k5");

    $display("[TB] Illegal kernel sizes");
    apply_stimulus(0, 0);
    check_output("k0_done", {31'd0, done}, 32'd1);
    check_output("k0_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check_output("k0_done_low", {31'd0, done}, 32'd0);
    apply_stimulus(7, 0);
    check_output("k7_done", {31'd0, done}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check_output("illegal_no_results", result_count, 32'd0);
    check_output("illegal_valid", {31'd0, res_if.result_valid}, 32'd0);

    $display("[TB] Reset during FETCH");
    write_weight(0, 3, 1'b1);
    apply_stimulus(3, 0);
    repeat (3) @(posedge clk);
    #1;
    check_output("busy_before_reset", {31'd0, busy}, 32'd1);
    d0    = done_count;
    rst_n = 1'b0;
    #1;
    check_output("rst_addr", {22'd0, bram_address}, 32'd0);
    check_output("rst_result", {8'd0, res_if.result}, 32'd0);
    check_output("rst_valid", {31'd0, res_if.result_valid}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 32; i++) w_model[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("no_done_on_reset", done_count - d0, 32'd0);
    apply_stimulus(1, 0);
    wait_done(784 * 3 + 50, "k1_cleared");

    $display("[TB] Reloaded random kernel, K=2, random ready");
    for (int i = 0; i < 25; i++) write_weight(i, int'($urandom_range(0, 255)), 1'b1);
    rdy_mode = 1;
    apply_stimulus(2, 900);
    wait_done(729 * 40, "k2_random");
    rdy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_engine.md
# conv_window_engine

Convolution stage directly downstream of the kernel loader. It captures the kernel weights the loader writes into an internal kernel register file, then sweeps a valid-mode K×K window across a square image held in BRAM. It produces one signed accumulated result per output pixel, in row-major order, over a valid/ready handshake to the next NPU stage.

## Interface
- KERNEL_REG_ADDR_WIDTH, 5, kernel register index width (25 entries used)
- BRAM_ADDR_WIDTH, 10, image BRAM address width
- WEIGHT_WIDTH, 8, signed two's-complement weight width
- PIXEL_WIDTH, 8, unsigned pixel width
- IMG_WIDTH, 28, image side length in pixels
- ACC_WIDTH, 24, signed accumulator/result width

Ports:
- Reset is asynchronous and active-low; the block uses a single clock.
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_kernal_wr_en  in  1  kernel register write strobe (from loader)
- i_kernal_reg_addr  in  KERNEL_REG_ADDR_WIDTH  kernel register write index
- i_kernal_data  in  WEIGHT_WIDTH  weight to write
- i_start  in  1  start sweep (sampled in IDLE only)
- i_kernal_size  in  3  K, sampled with i_start; legal values 1..5
- i_img_base_addr  in  BRAM_ADDR_WIDTH  BRAM address of pixel (0,0)
- o_bram_address  out  BRAM_ADDR_WIDTH  image read address
- i_bram_data  in  PIXEL_WIDTH  read data, 1-cycle latency
- o_result  out  ACC_WIDTH  window result
- o_result_valid  out  1  result available
- i_result_ready  in  1  consumer accepts result
- o_busy  out  1  sweep in progress
- o_done  out  1  one-cycle pulse at end of sweep

## Operation
- Kernel register file:
  - Writes are accepted only in IDLE when i_kernal_wr_en=1 and addr<25.
  - Writes are ignored while busy and when addr≥25.
  - Tap index = ky*K+kx.
- States:
  - IDLE: o_busy=0.
    - On i_start with a legal K: latch K and base, row=col=0, go to FETCH.
    - On i_start with an illegal K (0, 6, 7): pulse o_done on the next cycle, stay IDLE, produce no results.
  - FETCH: one tap per cycle, K*K cycles.
    - Address = base + (row+ky)*IMG_WIDTH + (col+kx), modulo 2^BRAM_ADDR_WIDTH.
    - The accumulator adds the product of the previous tap's data and weight.
  - DRAIN: one cycle; accumulate the last tap.
  - OUT: o_result_valid=1 and o_result holds until transfer (valid&&ready).
    - On transfer with more windows remaining: advance col; at col = IMG_WIDTH-K, wrap col to 0 and increment row. Go to FETCH.
    - On transfer of the last window (row=col=IMG_WIDTH-K): pulse o_done, go to IDLE.
- Arithmetic:
  - Product = signed weight × zero-extended pixel, width WEIGHT_WIDTH+PIXEL_WIDTH+1.
  - Product is sign-extended to ACC_WIDTH and added with two's-complement wrap (no saturation).
  - The accumulator clears at the start of each window.
- Result count is (IMG_WIDTH-K+1)².

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - All kernel registers 0.
  - Counters and accumulator 0.
- A reset mid-sweep aborts immediately. No o_done is issued.
- i_start is sampled at edge E0. The tap-0 address is driven after E0, and the data-to-address latency is 1 cycle.
- o_result_valid rises after edge E(K*K+1): edge E10 for K=3.
- On the transfer edge, the next window's tap-0 address is driven. Per-window period with ready held high is K*K+2 cycles.
- While ready=0 in OUT: o_result, o_bram_address and the counters are frozen.
- i_start while busy is ignored.
- o_done is high for exactly one cycle, coincident with the return to IDLE.

## Configuration
- CONV_RELU_EN defined: a negative accumulator is presented as 0 on o_result; non-negative values pass unchanged.
- Not defined: the raw signed accumulator is presented.
- Timing is identical in both builds.

## Structure
- Shared package npu_conv_pkg contains:
  - state encoding (IDLE, FETCH, DRAIN, OUT)
  - MAX_KERNEL_SIZE=5
  - MAX_KERNEL_TAPS=25
  - default IMG_WIDTH
- Sub-module kernel_reg_file: 25×WEIGHT_WIDTH registers with async reset, a gated write port and a combinational read by tap index.

## Test plan
- All 25 weights written as 1, K=3, base 0, BRAM[a]=a mod 256, ready high → first o_result=261 (0+1+2+28+29+30+56+57+58), 676 results, then a single o_done.
- K=3, result 1 pending, ready held low 5 cycles → o_result_valid, o_result and o_bram_address constant; the next address appears only after the transfer edge.
- Weight tap4=-1 (0xFF), others 0, all pixels 200 → every o_result=-200 without CONV_RELU_EN, 0 with it.
- K=5 → 576 results. K=1 with weight 2 → 784 results, each equal to 2×pixel.
- i_kernal_size=0 with i_start → o_done one cycle later, o_result_valid never asserted. A kernel write issued while busy → weight unchanged in the next sweep.
- i_rst_n low mid-FETCH → all outputs 0, kernel registers cleared. A new sweep with reloaded weights then completes correctly.
